// File: rtl/vecreg_wr_arb_pkg.sv
// Shared types and defaults for the vector register write-port arbiter.
// Holds default widths, the arbitration source encoding and the modular
// stamp-age compare used to order same-index writes.
package vecreg_wr_arb_pkg;

  localparam int VR_PROC_WTH_DEF   = 32;
  localparam int VR_PROC_PARAL_DEF = 64;
  localparam int VR_DATA_WTH_DEF   = VR_PROC_PARAL_DEF * VR_PROC_WTH_DEF;
  localparam int VR_IND_WTH_DEF    = 4;
  localparam int FIFO_DEP_DEF      = 2;
  localparam int STAMP_WTH_DEF     = 4;
  localparam int STARVE_MAX_DEF    = 3;

  typedef enum logic [1:0] {
    SRC_NONE,
    SRC_MPU,
    SRC_VPU
  } arb_src_e;

  // a is older than b when bit (wth-1) of the wrapped difference a-b is set;
  // stamps are zero-extended so the low wth bits of the difference are exact.
  function automatic logic stamp_older(input logic [31:0] a,
                                       input logic [31:0] b,
                                       input int          wth);
    logic [31:0] diff;
    diff = a - b;
    return |(diff & (32'd1 << (wth - 1)));
  endfunction

endpackage

// File: rtl/vecreg_wr_fifo.sv
// Small synchronous FIFO holding one source's pending register writes.
// Head is visible the cycle after the push; pop takes effect at the edge.
// No internal backpressure: caller must not push when full or pop when empty.
module vecreg_wr_fifo #(
  parameter int WTH = 8,
  parameter int DEP = 2
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           push_i,
  input  logic [WTH-1:0] push_dat_i,
  input  logic           pop_i,
  output logic [WTH-1:0] head_dat_o,
  output logic           full_o,
  output logic           empty_o
);

  localparam int AW = (DEP > 1) ? $clog2(DEP) : 1;
  localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

  logic [WTH-1:0] mem [DEP];
  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [AW:0]    wr_ptr;
  logic [AW:0]    rd_ptr;

  // Pointer update; reset discards everything buffered.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_i) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop_i)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // Storage write; contents need no reset since the pointers gate visibility.
  always_ff @(posedge clk_i) begin
    if (push_i) mem[wr_ptr[AW-1:0]] <= push_dat_i;
  end

  assign head_dat_o = mem[rd_ptr[AW-1:0]];
  assign empty_o    = (wr_ptr == rd_ptr);
  assign full_o     = (wr_ptr[AW] != rd_ptr[AW]) &&
                      (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/vecreg_wr_arb.sv
// Merges MPU and VPU vector-register writes onto the register file write ports.
// Latency 2 cycles from push edge to registered write; one write per cycle total.
// ready_o is low only when that source's FIFO is full (or in reset); no bypass.
module vecreg_wr_arb
  import vecreg_wr_arb_pkg::*;
#(
  parameter int VR_PROC_WTH   = VR_PROC_WTH_DEF,
  parameter int VR_PROC_PARAL = VR_PROC_PARAL_DEF,
  parameter int VR_DATA_WTH   = VR_PROC_PARAL * VR_PROC_WTH,
  parameter int VR_IND_WTH    = VR_IND_WTH_DEF,
  parameter int FIFO_DEP      = FIFO_DEP_DEF,
  parameter int STAMP_WTH     = STAMP_WTH_DEF,
  parameter int STARVE_MAX    = STARVE_MAX_DEF
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [VR_IND_WTH-1:0]  mpu_arb__windex_i,
  input  logic [VR_DATA_WTH-1:0] mpu_arb__wdata_i,
  input  logic                   mpu_arb__valid_i,
  output logic                   mpu_arb__ready_o,
  input  logic [VR_IND_WTH-1:0]  vpu_arb__windex_i,
  input  logic [VR_DATA_WTH-1:0] vpu_arb__wdata_i,
  input  logic                   vpu_arb__valid_i,
  output logic                   vpu_arb__ready_o,
  output logic [VR_IND_WTH-1:0]  mpu_vr__windex_o,
  output logic                   mpu_vr__we_o,
  output logic [VR_DATA_WTH-1:0] mpu_vr__wdata_o,
  output logic                   mpu_vr__wdata_act_o,
  output logic [VR_IND_WTH-1:0]  vpu_vr__rd_windex_o,
  output logic                   vpu_vr__rd_we_o,
  output logic [VR_DATA_WTH-1:0] vpu_vr__rd_wdata_o,
  output logic                   vpu_vr__rd_wdata_act_o,
  output logic                   arb__idle_o
);

  localparam int SW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
  localparam logic [SW-1:0]        STARVE_LIM = SW'(STARVE_MAX);
  localparam logic [SW-1:0]        STARVE_ONE = SW'(1);
  localparam logic [STAMP_WTH-1:0] STAMP_ONE  = STAMP_WTH'(1);

  typedef struct packed {
    logic [STAMP_WTH-1:0]   stamp;
    logic [VR_IND_WTH-1:0]  index;
    logic [VR_DATA_WTH-1:0] data;
  } wr_ent_t;

  localparam int ENT_WTH = $bits(wr_ent_t);

  logic [STAMP_WTH-1:0] stamp_q;
  logic [SW-1:0]        starve_q;
  wr_ent_t              mpu_in, vpu_in, mpu_head, vpu_head;
  logic                 mpu_full, mpu_empty, vpu_full, vpu_empty;
  logic                 mpu_push, vpu_push;
  arb_src_e             win;

  // Ready depends only on FIFO occupancy, never on the incoming valid.
  assign mpu_arb__ready_o = !rst_i && !mpu_full;
  assign vpu_arb__ready_o = !rst_i && !vpu_full;
  assign mpu_push = mpu_arb__valid_i && mpu_arb__ready_o;
  assign vpu_push = vpu_arb__valid_i && vpu_arb__ready_o;

  // Both sources pushing in one cycle share a stamp, which marks them as tied.
  assign mpu_in = '{stamp: stamp_q, index: mpu_arb__windex_i, data: mpu_arb__wdata_i};
  assign vpu_in = '{stamp: stamp_q, index: vpu_arb__windex_i, data: vpu_arb__wdata_i};

  vecreg_wr_fifo #(.WTH(ENT_WTH), .DEP(FIFO_DEP)) u_mpu_fifo (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .push_i     (mpu_push),
    .push_dat_i (mpu_in),
    .pop_i      (win == SRC_MPU),
    .head_dat_o (mpu_head),
    .full_o     (mpu_full),
    .empty_o    (mpu_empty)
  );

  vecreg_wr_fifo #(.WTH(ENT_WTH), .DEP(FIFO_DEP)) u_vpu_fifo (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .push_i     (vpu_push),
    .push_dat_i (vpu_in),
    .pop_i      (win == SRC_VPU),
    .head_dat_o (vpu_head),
    .full_o     (vpu_full),
    .empty_o    (vpu_empty)
  );

  // Pick the winning head. Same-index writes keep arrival order; on a tie the
  // VPU goes first so the MPU value lands last, as the register file would
  // resolve a simultaneous write. Otherwise MPU wins unless VPU is starving.
  always_comb begin
    win = SRC_NONE;
    if (!mpu_empty && !vpu_empty) begin
      if (mpu_head.index == vpu_head.index) begin
        if (mpu_head.stamp == vpu_head.stamp)
          win = SRC_VPU;
        else if (stamp_older(32'(vpu_head.stamp), 32'(mpu_head.stamp), STAMP_WTH))
          win = SRC_VPU;
        else
          win = SRC_MPU;
      end else if (starve_q == STARVE_LIM) begin
        win = SRC_VPU;
      end else begin
        win = SRC_MPU;
      end
    end else if (!mpu_empty) begin
      win = SRC_MPU;
    end else if (!vpu_empty) begin
      win = SRC_VPU;
    end
  end

  // Free-running stamp and saturating count of consecutive VPU losses.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stamp_q  <= '0;
      starve_q <= '0;
    end else begin
      stamp_q <= stamp_q + STAMP_ONE;
      if (vpu_empty || win == SRC_VPU)
        starve_q <= '0;
      else if (starve_q != STARVE_LIM)
        starve_q <= starve_q + STARVE_ONE;
    end
  end

  // Registered write ports; the idle port keeps its last index and data.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mpu_vr__we_o        <= 1'b0;
      mpu_vr__windex_o    <= '0;
      mpu_vr__wdata_o     <= '0;
      vpu_vr__rd_we_o     <= 1'b0;
      vpu_vr__rd_windex_o <= '0;
      vpu_vr__rd_wdata_o  <= '0;
    end else begin
      mpu_vr__we_o    <= (win == SRC_MPU);
      vpu_vr__rd_we_o <= (win == SRC_VPU);
      if (win == SRC_MPU) begin
        mpu_vr__windex_o <= mpu_head.index;
        mpu_vr__wdata_o  <= mpu_head.data;
      end
      if (win == SRC_VPU) begin
        vpu_vr__rd_windex_o <= vpu_head.index;
        vpu_vr__rd_wdata_o  <= vpu_head.data;
      end
    end
  end

  assign mpu_vr__wdata_act_o    = mpu_vr__we_o;
  assign vpu_vr__rd_wdata_act_o = vpu_vr__rd_we_o;
  assign arb__idle_o = rst_i ||
                       (mpu_empty && vpu_empty && !mpu_vr__we_o && !vpu_vr__rd_we_o);

endmodule

// File: tb/tb_vecreg_wr_arb.sv
module tb_vecreg_wr_arb;
  import vecreg_wr_arb_pkg::*;

  localparam int DW = VR_DATA_WTH_DEF;
  localparam int IW = VR_IND_WTH_DEF;
  typedef logic [DW-1:0] dat_t;
  typedef logic [IW-1:0] idx_t;
  typedef struct {
    bit   vpu;
    idx_t idx;
    dat_t dat;
    int   cyc;
  } exp_t;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  idx_t mpu_arb__windex_i = '0;
  dat_t mpu_arb__wdata_i = '0;
  logic mpu_arb__valid_i = 1'b0;
  logic mpu_arb__ready_o;
  idx_t vpu_arb__windex_i = '0;
  dat_t vpu_arb__wdata_i = '0;
  logic vpu_arb__valid_i = 1'b0;
  logic vpu_arb__ready_o;
  idx_t mpu_vr__windex_o;
  logic mpu_vr__we_o;
  dat_t mpu_vr__wdata_o;
  logic mpu_vr__wdata_act_o;
  idx_t vpu_vr__rd_windex_o;
  logic vpu_vr__rd_we_o;
  dat_t vpu_vr__rd_wdata_o;
  logic vpu_vr__rd_wdata_act_o;
  logic arb__idle_o;

  vecreg_wr_arb dut (
    .clk_i                  (clk_i),
    .rst_i                  (rst_i),
    .mpu_arb__windex_i      (mpu_arb__windex_i),
    .mpu_arb__wdata_i       (mpu_arb__wdata_i),
    .mpu_arb__valid_i       (mpu_arb__valid_i),
    .mpu_arb__ready_o       (mpu_arb__ready_o),
    .vpu_arb__windex_i      (vpu_arb__windex_i),
    .vpu_arb__wdata_i       (vpu_arb__wdata_i),
    .vpu_arb__valid_i       (vpu_arb__valid_i),
    .vpu_arb__ready_o       (vpu_arb__ready_o),
    .mpu_vr__windex_o       (mpu_vr__windex_o),
    .mpu_vr__we_o           (mpu_vr__we_o),
    .mpu_vr__wdata_o        (mpu_vr__wdata_o),
    .mpu_vr__wdata_act_o    (mpu_vr__wdata_act_o),
    .vpu_vr__rd_windex_o    (vpu_vr__rd_windex_o),
    .vpu_vr__rd_we_o        (vpu_vr__rd_we_o),
    .vpu_vr__rd_wdata_o     (vpu_vr__rd_wdata_o),
    .vpu_vr__rd_wdata_act_o (vpu_vr__rd_wdata_act_o),
    .arb__idle_o            (arb__idle_o)
  );

  initial forever #5 clk_i = ~clk_i;

  int   cyc = 0;
  int   n_chk = 0;
  int   n_pass = 0;
  int   n_wr = 0;
  int   rst_cyc = 0;
  exp_t exp_q[$];
  dat_t rf [16];
  idx_t last_m_idx = '0, last_v_idx = '0;
  dat_t last_m_dat = '0, last_v_dat = '0;

  always @(posedge clk_i) cyc <= cyc + 1;

  function automatic dat_t pat(input logic [31:0] s);
    return {(DW / 32){s}};
  endfunction

  task automatic check(input string tag, input dat_t got, input dat_t want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0h want %0h (low 64 bits shown) at cycle %0d",
                  tag, got[63:0], want[63:0], cyc);
  endtask

  task automatic exp_wr(input bit vpu, input idx_t idx, input dat_t dat, input int c);
    exp_t e;
    e.vpu = vpu; e.idx = idx; e.dat = dat; e.cyc = c;
    exp_q.push_back(e);
  endtask

  // Drives one cycle of requests; returns the ready values seen that cycle.
  task automatic drive(input bit mv, input idx_t mi, input dat_t md,
                       input bit vv, input idx_t vi, input dat_t vd,
                       output bit m_rdy, output bit v_rdy);
    mpu_arb__valid_i = mv; mpu_arb__windex_i = mi; mpu_arb__wdata_i = md;
    vpu_arb__valid_i = vv; vpu_arb__windex_i = vi; vpu_arb__wdata_i = vd;
    @(negedge clk_i);
    m_rdy = mpu_arb__ready_o;
    v_rdy = vpu_arb__ready_o;
    if (mv) check("mpu_push_rdy", DW'(m_rdy), DW'(1));
    if (vv) check("vpu_push_rdy", DW'(v_rdy), DW'(1));
    @(posedge clk_i); #1;
    mpu_arb__valid_i = 1'b0;
    vpu_arb__valid_i = 1'b0;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      step(1);
      n++;
    end
    check("drain", DW'(exp_q.size()), DW'(0));
    step(2);
  endtask

  task automatic reset_dut();
    rst_i = 1'b1;
    @(negedge clk_i);
    check("rst_mpu_rdy", DW'(mpu_arb__ready_o), DW'(0));
    check("rst_vpu_rdy", DW'(vpu_arb__ready_o), DW'(0));
    check("rst_mpu_we", DW'(mpu_vr__we_o), DW'(0));
    check("rst_vpu_we", DW'(vpu_vr__rd_we_o), DW'(0));
    check("rst_idle", DW'(arb__idle_o), DW'(1));
    @(negedge clk_i);
    check("rst_mpu_idx", DW'(mpu_vr__windex_o), DW'(0));
    check("rst_mpu_dat", mpu_vr__wdata_o, '0);
    check("rst_vpu_idx", DW'(vpu_vr__rd_windex_o), DW'(0));
    check("rst_vpu_dat", vpu_vr__rd_wdata_o, '0);
    check("rst_act", DW'({mpu_vr__wdata_act_o, vpu_vr__rd_wdata_act_o}), DW'(0));
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    rst_cyc = cyc;
    last_m_idx = '0; last_m_dat = '0;
    last_v_idx = '0; last_v_dat = '0;
    @(negedge clk_i);
    check("post_rst_mpu_rdy", DW'(mpu_arb__ready_o), DW'(1));
    check("post_rst_vpu_rdy", DW'(vpu_arb__ready_o), DW'(1));
    check("post_rst_idle", DW'(arb__idle_o), DW'(1));
    @(posedge clk_i); #1;
  endtask

  // Write-port monitor: every issued write must match the scoreboard head.
  always @(negedge clk_i) begin
    if (!rst_i) begin
      if (mpu_vr__we_o || mpu_vr__wdata_act_o)
        check("mpu_act", DW'(mpu_vr__wdata_act_o), DW'(mpu_vr__we_o));
      if (vpu_vr__rd_we_o || vpu_vr__rd_wdata_act_o)
        check("vpu_act", DW'(vpu_vr__rd_wdata_act_o), DW'(vpu_vr__rd_we_o));
      if (mpu_vr__we_o || vpu_vr__rd_we_o) begin
        n_wr++;
        check("one_we", DW'(mpu_vr__we_o & vpu_vr__rd_we_o), DW'(0));
        if (exp_q.size() == 0) begin
          check("spurious_wr", DW'({mpu_vr__we_o, vpu_vr__rd_we_o}), DW'(0));
        end else begin
          exp_t e;
          idx_t gi;
          dat_t gd;
          e  = exp_q.pop_front();
          gi = vpu_vr__rd_we_o ? vpu_vr__rd_windex_o : mpu_vr__windex_o;
          gd = vpu_vr__rd_we_o ? vpu_vr__rd_wdata_o : mpu_vr__wdata_o;
          check("wr_port_vpu", DW'(vpu_vr__rd_we_o), DW'(e.vpu));
          check("wr_idx", DW'(gi), DW'(e.idx));
          check("wr_dat", gd, e.dat);
          check("wr_cyc", DW'(cyc), DW'(e.cyc));
          if (e.vpu) begin
            check("mpu_hold_idx", DW'(mpu_vr__windex_o), DW'(last_m_idx));
            check("mpu_hold_dat", mpu_vr__wdata_o, last_m_dat);
            last_v_idx = e.idx; last_v_dat = e.dat;
          end else begin
            check("vpu_hold_idx", DW'(vpu_vr__rd_windex_o), DW'(last_v_idx));
            check("vpu_hold_dat", vpu_vr__rd_wdata_o, last_v_dat);
            last_m_idx = e.idx; last_m_dat = e.dat;
          end
          rf[gi] = gd;
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit mr, vr;
    int c;
    int wr_before;

    // Reset state
    reset_dut();

    // Single MPU write: 2-cycle latency, idle returns afterwards
    c = cyc;
    exp_wr(0, 4'd3, pat(32'hAAAA_0003), c + 2);
    drive(1, 4'd3, pat(32'hAAAA_0003), 0, '0, '0, mr, vr);
    @(negedge clk_i);
    check("idle_busy", DW'(arb__idle_o), DW'(0));
    @(negedge clk_i);
    @(negedge clk_i);
    check("idle_back", DW'(arb__idle_o), DW'(1));
    step(1);
    wait_drain();

    // Same index, same cycle: VPU first so MPU value ends up in the file
    c = cyc;
    exp_wr(1, 4'd5, pat(32'h0B0B_0505), c + 2);
    exp_wr(0, 4'd5, pat(32'h0A0A_0505), c + 3);
    drive(1, 4'd5, pat(32'h0A0A_0505), 1, 4'd5, pat(32'h0B0B_0505), mr, vr);
    wait_drain();
    check("rf5_final", rf[5], pat(32'h0A0A_0505));

    // Different indices, same cycle: MPU first, nothing lost
    c = cyc;
    exp_wr(0, 4'd1, pat(32'hC000_0001), c + 2);
    exp_wr(1, 4'd2, pat(32'hD000_0002), c + 3);
    drive(1, 4'd1, pat(32'hC000_0001), 1, 4'd2, pat(32'hD000_0002), mr, vr);
    wait_drain();
    check("rf1_final", rf[1], pat(32'hC000_0001));
    check("rf2_final", rf[2], pat(32'hD000_0002));

    // Starvation and VPU FIFO fill: VPU forced in after 3 MPU wins
    c = cyc;
    exp_wr(0, 4'd10, pat(32'h100), c + 2);
    exp_wr(0, 4'd11, pat(32'h101), c + 3);
    exp_wr(0, 4'd12, pat(32'h102), c + 4);
    exp_wr(1, 4'd14, pat(32'h200), c + 5);
    exp_wr(0, 4'd13, pat(32'h103), c + 6);
    exp_wr(1, 4'd15, pat(32'h201), c + 7);
    drive(1, 4'd10, pat(32'h100), 1, 4'd14, pat(32'h200), mr, vr);
    drive(1, 4'd11, pat(32'h101), 1, 4'd15, pat(32'h201), mr, vr);
    drive(1, 4'd12, pat(32'h102), 0, '0, '0, mr, vr);
    check("vpu_full_rdy_a", DW'(vr), DW'(0));
    drive(1, 4'd13, pat(32'h103), 0, '0, '0, mr, vr);
    check("vpu_full_rdy_b", DW'(vr), DW'(0));
    drive(0, '0, '0, 0, '0, '0, mr, vr);
    check("vpu_full_rdy_c", DW'(vr), DW'(0));
    drive(0, '0, '0, 0, '0, '0, mr, vr);
    check("vpu_rdy_after_pop", DW'(vr), DW'(1));
    wait_drain();

    // Reset while both FIFOs hold entries: nothing is ever issued
    wr_before = n_wr;
    drive(1, 4'd7, pat(32'h7777_0007), 1, 4'd8, pat(32'h8888_0008), mr, vr);
    reset_dut();
    step(6);
    check("rst_discard", DW'(n_wr), DW'(wr_before));
    check("rst_discard_q", DW'(exp_q.size()), DW'(0));

    // Stamp wrap: VPU entry stamped 15, MPU entry stamped 0 (wrapped); VPU is older
    while (((cyc - rst_cyc) % 16) != 15 || (cyc - rst_cyc) < 20) step(1);
    c = cyc;
    exp_wr(0, 4'd8, pat(32'h6000_0008), c + 2);
    exp_wr(1, 4'd9, pat(32'hE000_0009), c + 3);
    exp_wr(0, 4'd9, pat(32'hF000_0009), c + 4);
    drive(1, 4'd8, pat(32'h6000_0008), 1, 4'd9, pat(32'hE000_0009), mr, vr);
    drive(1, 4'd9, pat(32'hF000_0009), 0, '0, '0, mr, vr);
    wait_drain();
    check("rf9_final", rf[9], pat(32'hF000_0009));
    check("final_idle", DW'(arb__idle_o), DW'(1));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/vecreg_wr_arb.md
Name: vecreg_wr_arb

Overview:
Write-port arbiter placed directly upstream of the vector register file. It accepts vector-register write requests from the MPU result path and the VPU rd result path over valid/ready handshakes, and buffers each source in a small FIFO. It issues at most one write per cycle to the register file's mpu/vpu write ports. No write is ever dropped by a same-cycle collision, and same-index writes complete in a defined order.

Parameters:
VR_PROC_WTH, 32, bits per lane element
VR_PROC_PARAL, 64, lanes per vector
VR_DATA_WTH, VR_PROC_PARAL*VR_PROC_WTH, vector write data width
VR_IND_WTH, 4, register index width
FIFO_DEP, 2, entries per source FIFO (power of 2, >=2)
STAMP_WTH, 4, arrival-stamp width (2^(STAMP_WTH-1) > 2*FIFO_DEP+STARVE_MAX)
STARVE_MAX, 3, consecutive VPU losses before VPU is forced to win

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
mpu_arb__windex_i  in  VR_IND_WTH  MPU write index
mpu_arb__wdata_i  in  VR_DATA_WTH  MPU write data
mpu_arb__valid_i  in  1  MPU request valid
mpu_arb__ready_o  out  1  MPU FIFO not full
vpu_arb__windex_i  in  VR_IND_WTH  VPU rd write index
vpu_arb__wdata_i  in  VR_DATA_WTH  VPU rd write data
vpu_arb__valid_i  in  1  VPU request valid
vpu_arb__ready_o  out  1  VPU FIFO not full
mpu_vr__windex_o  out  VR_IND_WTH  to vecreg MPU write index
mpu_vr__we_o  out  1  to vecreg MPU write enable
mpu_vr__wdata_o  out  VR_DATA_WTH  to vecreg MPU write data
mpu_vr__wdata_act_o  out  1  equals mpu_vr__we_o
vpu_vr__rd_windex_o  out  VR_IND_WTH  to vecreg VPU write index
vpu_vr__rd_we_o  out  1  to vecreg VPU write enable
vpu_vr__rd_wdata_o  out  VR_DATA_WTH  to vecreg VPU write data
vpu_vr__rd_wdata_act_o  out  1  equals vpu_vr__rd_we_o
arb__idle_o  out  1  both FIFOs empty and no write issuing

Behaviour:
- Single clock clk_i; reset rst_i synchronous, active-high.
- Reset: FIFOs flushed and pointers cleared; stamp counter = 0; starve counter = 0.
- Output values during/after reset: we/act outputs = 0, index/data outputs = 0, ready_o = 0 while rst_i = 1, arb__idle_o = 1.
- Reset mid-operation: all buffered writes are discarded without being issued.
- Handshake: a transfer occurs when valid_i && ready_o at a clock edge. ready_o = !full and is registered-path combinational from FIFO state only, never from valid_i. Push when full is impossible.
- Stamp counter: free-running STAMP_WTH-bit counter that wraps. Each pushed entry stores {index, data, stamp}. Both sources pushed in the same cycle receive the same stamp.
- Latency: push at edge N, arbitrated during cycle N+1, write outputs asserted cycle N+2 (registered). Minimum latency is 2 cycles. Throughput is one write per cycle total.
- Outputs are registered. Exactly one of mpu_vr__we_o and vpu_vr__rd_we_o is high per cycle, or neither. The inactive port's index/data hold their last values.
- Arbitration when both heads are valid, first matching rule applies:
  1. Same index, different stamps: the older entry wins. Age uses modular compare: older if MSB of (a-b) is 1.
  2. Same index, equal stamps: VPU wins, so MPU's value is written last and ends up in the register file, matching the register file's MPU-over-VPU priority.
  3. Starve counter == STARVE_MAX: VPU wins.
  4. Otherwise: MPU wins.
- Starve counter: increments when the VPU head is valid and loses; clears when VPU wins or the VPU FIFO is empty. It saturates at STARVE_MAX.
- Single valid head: that head wins.
- Pop and push on the same FIFO in the same cycle is allowed when full: the pop frees the slot, but ready_o stays low that cycle because ready is not a bypass.
- Pointers wrap modulo FIFO_DEP, using an extra wrap bit for full/empty detection.

Decomposition:
- Shared package: VR_IND_WTH, VR_DATA_WTH defaults; a stamp compare function; an arbitration-source enum {SRC_NONE, SRC_MPU, SRC_VPU}.
- One sub-module, vecreg_wr_fifo: parameterised width/depth synchronous FIFO with full/empty outputs. It is instantiated twice, with payload = {stamp, index, data}.

Test Plan:
- Reset, then one MPU push (index 3, data A): mpu_vr__we_o = 1 with index 3, data A exactly 2 cycles after the push; vpu_vr__rd_we_o stays 0; idle returns to 1 the following cycle.
- Same-cycle pushes MPU (idx 5, A) and VPU (idx 5, B): VPU write issued in cycle N+2, MPU write in N+3; final register value = A.
- Same-cycle pushes to different indices (MPU idx 1, VPU idx 2): MPU is written first, VPU next cycle; no write lost.
- MPU valid held high continuously with VPU valid: VPU write is issued after exactly STARVE_MAX = 3 MPU wins; starve counter then clears.
- Stall fill: hold VPU losing until the VPU FIFO holds 2 entries: vpu_arb__ready_o = 0; it rises the cycle after the first pop.
- Assert rst_i while both FIFOs hold entries: no we outputs are asserted afterwards; ready_o = 0 during reset; idle = 1 after reset.
- Stamp wrap: run 20+ cycles so the stamp counter wraps, then issue a same-index cross-source pair with different stamps: the older entry is written first.
